// File: rtl/map_loader.sv
// map_loader: streams one stored puzzle map (value + visibility per cell) over a valid/ready port.
// Optional range checker on streamed values is enabled by defining MAP_LOADER_CHECK_EN.
module map_loader #(
    parameter int unsigned NUM_MAPS  = 8,
    parameter int unsigned NUM_CELLS = 81
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              difficulty,
    input  logic [2:0]                        map_sel,
    input  logic [NUM_MAPS*NUM_CELLS*4-1:0]   maps_easy,
    input  logic [NUM_MAPS*NUM_CELLS*4-1:0]   maps_hard,
    input  logic [NUM_MAPS*NUM_CELLS*2-1:0]   visibilities_easy,
    input  logic [NUM_MAPS*NUM_CELLS*2-1:0]   visibilities_hard,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [6:0]                        cell_idx,
    output logic [3:0]                        cell_value,
    output logic                              cell_visible,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int unsigned TOTAL_CELLS = NUM_MAPS * NUM_CELLS;
    localparam int unsigned CELL_AW     = $clog2(TOTAL_CELLS);
    localparam int unsigned IDX_W       = 7;
    localparam int unsigned SEL_W       = 3;
    localparam int unsigned VAL_W       = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t             r_state, w_state_n;
    logic [IDX_W-1:0]   r_cnt, w_cnt_n;
    logic               r_diff, w_diff_n;
    logic [SEL_W-1:0]   r_sel, w_sel_n;

    logic               r_valid, r_busy, r_done, r_vis;
    logic [IDX_W-1:0]   r_idx;
    logic [VAL_W-1:0]   r_value;

    logic               w_valid_n, w_busy_n, w_done_n, w_vis_n;
    logic [IDX_W-1:0]   w_idx_n;
    logic [VAL_W-1:0]   w_value_n;
    logic [CELL_AW-1:0] w_cell, w_rcell;
    logic               w_xfer;

    assign w_xfer = r_valid & out_ready;

    // State and latched selection, plus registered beat outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_diff  <= 1'b0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_value <= '0;
            r_vis   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_diff  <= w_diff_n;
            r_sel   <= w_sel_n;
            r_valid <= w_valid_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_idx   <= w_idx_n;
            r_value <= w_value_n;
            r_vis   <= w_vis_n;
        end
    end

    // Next-state: selection is captured only when a start is accepted in IDLE
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_diff_n  = r_diff;
        w_sel_n   = r_sel;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_n = S_STREAM;
                    w_cnt_n   = '0;
                    w_diff_n  = difficulty;
                    w_sel_n   = SEL_W'(32'(map_sel) % NUM_MAPS);
                end
            end
            S_STREAM: begin
                if (w_xfer) begin
                    if (r_cnt == LAST_IDX) w_state_n = S_DONE;
                    else                   w_cnt_n   = r_cnt + IDX_W'(1);
                end
            end
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // Output lookup for the next cycle; bus is MSB-first so reverse the flat cell index
    always_comb begin
        w_valid_n = (w_state_n == S_STREAM);
        w_busy_n  = (w_state_n != S_IDLE);
        w_done_n  = (w_state_n == S_DONE);
        w_cell    = CELL_AW'(w_sel_n) * CELL_AW'(NUM_CELLS) + CELL_AW'(w_cnt_n);
        w_rcell   = CELL_AW'(TOTAL_CELLS - 1) - w_cell;
        w_idx_n   = '0;
        w_value_n = '0;
        w_vis_n   = 1'b0;
        if (w_valid_n) begin
            w_idx_n = w_cnt_n;
            if (w_diff_n) begin
                w_value_n = maps_hard[{w_rcell, 2'b00} +: VAL_W];
                w_vis_n   = &visibilities_hard[{w_rcell, 1'b0} +: 2];
            end else begin
                w_value_n = maps_easy[{w_rcell, 2'b00} +: VAL_W];
                w_vis_n   = &visibilities_easy[{w_rcell, 1'b0} +: 2];
            end
        end
    end

    assign out_valid    = r_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign cell_idx     = r_idx;
    assign cell_value   = r_value;
    assign cell_visible = r_vis;

`ifdef MAP_LOADER_CHECK_EN
    logic r_err;
    logic w_bad;

    assign w_bad = (r_value == VAL_W'(0)) || (r_value > VAL_W'(9));

    // Sticky until the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            r_err <= 1'b0;
        else if (r_state == S_IDLE && start) r_err <= 1'b0;
        else if (w_xfer && w_bad)           r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
